// File: rtl/uart_tx_arbiter.sv
// Round-robin (or fixed-priority with TXARB_FIXED_PRIO_EN) scheduler of two byte sources onto one uart_tx.
// Grant registered one cycle after req & tx_ready in IDLE; requests are ignored until the frame plus GAP cycles ends.
module uart_tx_arbiter #(
  parameter int unsigned GAP = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic [7:0] data0,
  output logic       ack0,
  input  logic       req1,
  input  logic [7:0] data1,
  output logic       ack1,
  input  logic       tx_ready,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       busy,
  output logic       owner
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_GAP
  } state_t;

  localparam logic [15:0] GAP_LOAD = 16'((GAP != 0) ? (GAP - 32'd1) : 32'd0);

  state_t      state, state_nxt;
  logic [15:0] gap_cnt, gap_cnt_nxt;
  logic        grant;
  logic        pick1;

`ifdef TXARB_FIXED_PRIO_EN
  assign pick1 = req1 & ~req0;
`else
  // On a tie the requester that did not win last time is served.
  assign pick1 = req1 & (~req0 | ~owner);
`endif

  always_comb begin
    state_nxt   = state;
    gap_cnt_nxt = gap_cnt;
    grant       = 1'b0;
    case (state)
      S_IDLE: begin
        if ((req0 | req1) & tx_ready) begin
          grant     = 1'b1;
          state_nxt = S_WAIT_BUSY;
        end
      end
      S_WAIT_BUSY: begin
        if (!tx_ready) state_nxt = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (tx_ready) begin
          if (GAP != 0) begin
            state_nxt   = S_GAP;
            gap_cnt_nxt = GAP_LOAD;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt == 16'd0) state_nxt = S_IDLE;
        else                  gap_cnt_nxt = gap_cnt - 16'd1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      gap_cnt <= 16'd0;
    end else begin
      state   <= state_nxt;
      gap_cnt <= gap_cnt_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_start <= 1'b0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      tx_data  <= 8'h00;
      owner    <= 1'b1;
    end else begin
      tx_start <= grant;
      ack0     <= grant & ~pick1;
      ack1     <= grant & pick1;
      if (grant) begin
        tx_data <= pick1 ? data1 : data0;
        owner   <= pick1;
      end
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: cycle table, reset sequences, randomized queues vs. arbitration model, GAP instance.
module tb_uart_tx_arbiter;

`ifdef TXARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif
  localparam int GAP_N = 5;
  localparam int G_FRAME = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       req0 = 0, req1 = 0, tb_ready = 0, use_model = 0;
  logic [7:0] data0 = 0, data1 = 0;
  logic       tx_ready, tx_start, ack0, ack1, busy, owner;
  logic [7:0] tx_data;

  logic       gap_req = 0;
  logic       g_ready, g_start, g_ack0, g_ack1, g_busy, g_owner;
  logic [7:0] g_data;

  int n_chk = 0;
  int n_fail = 0;

  // Transmitter model: a frame of m_len cycles counts the start cycle, so tx_ready is low m_len-1 cycles.
  int m_cnt = 0;
  int m_len = 4;
  int g_cnt = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) m_cnt <= 0;
    else if (tx_start && m_cnt == 0) m_cnt <= m_len - 1;
    else if (m_cnt != 0) m_cnt <= m_cnt - 1;
  end
  always @(posedge clk or posedge rst) begin
    if (rst) g_cnt <= 0;
    else if (g_start && g_cnt == 0) g_cnt <= G_FRAME - 1;
    else if (g_cnt != 0) g_cnt <= g_cnt - 1;
  end
  assign tx_ready = use_model ? (m_cnt == 0) : tb_ready;
  assign g_ready  = (g_cnt == 0);

  uart_tx_arbiter dut (
    .clk(clk), .rst(rst),
    .req0(req0), .data0(data0), .ack0(ack0),
    .req1(req1), .data1(data1), .ack1(ack1),
    .tx_ready(tx_ready), .tx_start(tx_start), .tx_data(tx_data),
    .busy(busy), .owner(owner)
  );

  uart_tx_arbiter #(.GAP(GAP_N)) dut_gap (
    .clk(clk), .rst(rst),
    .req0(gap_req), .data0(8'h5A), .ack0(g_ack0),
    .req1(1'b0), .data1(8'h00), .ack1(g_ack1),
    .tx_ready(g_ready), .tx_start(g_start), .tx_data(g_data),
    .busy(g_busy), .owner(g_owner)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    req0 = 0; req1 = 0; data0 = 0; data1 = 0; tb_ready = 0; gap_req = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  typedef struct {
    logic r0, r1; logic [7:0] d0, d1; logic rdy;
    logic st, a0, a1; logic [7:0] td; logic own, bsy;
  } vec_t;
  vec_t vt[$];

  task automatic add(input logic r0, r1, input logic [7:0] d0, d1, input logic rdy,
                     input logic st, a0, a1, input logic [7:0] td, input logic own, bsy);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.d0 = d0; v.d1 = d1; v.rdy = rdy;
    v.st = st; v.a0 = a0; v.a1 = a1; v.td = td; v.own = own; v.bsy = bsy;
    vt.push_back(v);
  endtask

  // Reference arbitration: every byte queued up front, requesters stay asserted while non-empty.
  task automatic model_order(input logic [7:0] a[$], input logic [7:0] b[$],
                             output logic [7:0] ed[$], output logic eo[$]);
    logic own = 1'b1;
    logic pick;
    ed.delete(); eo.delete();
    while (a.size() > 0 || b.size() > 0) begin
      if (a.size() > 0 && b.size() > 0) pick = FIXED ? 1'b0 : ~own;
      else pick = (a.size() > 0) ? 1'b0 : 1'b1;
      if (pick) ed.push_back(b.pop_front()); else ed.push_back(a.pop_front());
      eo.push_back(pick);
      own = pick;
    end
  endtask

  task automatic run_random();
    logic [7:0] q0[$], q1[$], ed[$];
    logic eo[$];
    int total, k, cyc, last_start, prev_len;
    logic prev_st;
    apply_reset();
    use_model = 1;
    repeat ($urandom_range(1, 6)) q0.push_back(8'($urandom));
    repeat ($urandom_range(1, 6)) q1.push_back(8'($urandom));
    model_order(q0, q1, ed, eo);
    total = ed.size();
    k = 0; cyc = 0; last_start = -1; prev_st = 0;
    m_len = $urandom_range(2, 9);
    prev_len = m_len;
    req0 = (q0.size() > 0); if (req0) data0 = q0[0];
    req1 = (q1.size() > 0); if (req1) data1 = q1[0];
    while (k < total && cyc < 1500) begin
      @(posedge clk); #1;
      cyc++;
      chk("start_single_cycle", {31'd0, tx_start & prev_st}, 0);
      prev_st = tx_start;
      if (tx_start) begin
        chk("rand_tx_data", {24'd0, tx_data}, {24'd0, ed[k]});
        chk("rand_owner", {31'd0, owner}, {31'd0, eo[k]});
        chk("rand_ack0", {31'd0, ack0}, {31'd0, ~eo[k]});
        chk("rand_ack1", {31'd0, ack1}, {31'd0, eo[k]});
        if (last_start >= 0) chk("rand_spacing", cyc - last_start, prev_len + 2);
        last_start = cyc;
        m_len = $urandom_range(2, 9);
        prev_len = m_len;
        k++;
      end else begin
        chk("rand_ack_without_start", {30'd0, ack0, ack1}, 0);
      end
      if (ack0 && q0.size() > 0) void'(q0.pop_front());
      if (ack1 && q1.size() > 0) void'(q1.pop_front());
      req0 = (q0.size() > 0); if (req0) data0 = q0[0];
      req1 = (q1.size() > 0); if (req1) data1 = q1[0];
    end
    chk("rand_all_bytes_sent", k, total);
    use_model = 0;
  endtask

  initial begin
    int starts, last, bcnt, cyc;

    apply_reset();
    chk("reset_busy", {31'd0, busy}, 0);
    chk("reset_tx_start", {31'd0, tx_start}, 0);
    chk("reset_acks", {30'd0, ack0, ack1}, 0);
    chk("reset_tx_data", {24'd0, tx_data}, 0);
    chk("reset_owner", {31'd0, owner}, 1);
    chk("reset_gap_owner", {31'd0, g_owner}, 1);

    //   r0 r1 d0     d1     rdy  st a0      a1      td                  own     bsy
    add(0, 1, 8'h00, 8'h55, 0,   0, 0,      0,      8'h00,              1,      0);
    add(0, 1, 8'h00, 8'h55, 0,   0, 0,      0,      8'h00,              1,      0);
    add(0, 1, 8'h00, 8'h55, 1,   1, 0,      1,      8'h55,              1,      1);
    add(0, 0, 8'h00, 8'h55, 1,   0, 0,      0,      8'h55,              1,      1);
    add(0, 0, 8'h00, 8'h55, 0,   0, 0,      0,      8'h55,              1,      1);
    add(1, 0, 8'h4B, 8'h55, 0,   0, 0,      0,      8'h55,              1,      1);
    add(1, 0, 8'h4B, 8'h55, 1,   0, 0,      0,      8'h55,              1,      0);
    add(1, 0, 8'h4B, 8'h55, 1,   1, 1,      0,      8'h4B,              0,      1);
    add(0, 0, 8'h4B, 8'h55, 1,   0, 0,      0,      8'h4B,              0,      1);
    add(0, 0, 8'h4B, 8'h55, 0,   0, 0,      0,      8'h4B,              0,      1);
    add(0, 0, 8'h4B, 8'h55, 1,   0, 0,      0,      8'h4B,              0,      0);
    add(1, 1, 8'h41, 8'h42, 1,   1, FIXED, ~FIXED, FIXED ? 8'h41 : 8'h42, ~FIXED, 1);
    add(1, 1, 8'h41, 8'h42, 0,   0, 0,      0,      FIXED ? 8'h41 : 8'h42, ~FIXED, 1);
    add(1, 1, 8'h41, 8'h42, 1,   0, 0,      0,      FIXED ? 8'h41 : 8'h42, ~FIXED, 0);
    add(1, 1, 8'h41, 8'h42, 1,   1, 1,      0,      8'h41,              0,      1);
    add(0, 0, 8'h41, 8'h42, 0,   0, 0,      0,      8'h41,              0,      1);
    add(0, 0, 8'h41, 8'h42, 1,   0, 0,      0,      8'h41,              0,      0);
    add(0, 0, 8'h41, 8'h42, 1,   0, 0,      0,      8'h41,              0,      0);

    foreach (vt[i]) begin
      req0 = vt[i].r0; req1 = vt[i].r1; data0 = vt[i].d0; data1 = vt[i].d1; tb_ready = vt[i].rdy;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_tx_start", i), {31'd0, tx_start}, {31'd0, vt[i].st});
      chk($sformatf("vec%0d_ack0", i), {31'd0, ack0}, {31'd0, vt[i].a0});
      chk($sformatf("vec%0d_ack1", i), {31'd0, ack1}, {31'd0, vt[i].a1});
      chk($sformatf("vec%0d_tx_data", i), {24'd0, tx_data}, {24'd0, vt[i].td});
      chk($sformatf("vec%0d_owner", i), {31'd0, owner}, {31'd0, vt[i].own});
      chk($sformatf("vec%0d_busy", i), {31'd0, busy}, {31'd0, vt[i].bsy});
    end

    // Asynchronous reset while the start pulse is high.
    apply_reset();
    req0 = 1; data0 = 8'hC3; tb_ready = 1;
    @(posedge clk); #1;
    chk("pre_rst_start", {31'd0, tx_start}, 1);
    req0 = 0;
    #2 rst = 1;
    #1;
    chk("rst_grant_tx_start", {31'd0, tx_start}, 0);
    chk("rst_grant_ack0", {31'd0, ack0}, 0);
    chk("rst_grant_tx_data", {24'd0, tx_data}, 0);
    chk("rst_grant_busy", {31'd0, busy}, 0);
    #1 rst = 0;

    // Asynchronous reset in WAIT_DONE, then a fresh grant.
    req0 = 1; data0 = 8'h7E; tb_ready = 1;
    @(posedge clk); #1;
    chk("wd_grant_data", {24'd0, tx_data}, 8'h7E);
    req0 = 0; tb_ready = 0;
    @(posedge clk); #1;
    chk("wd_busy_before_rst", {31'd0, busy}, 1);
    #2 rst = 1;
    #1;
    chk("rst_wd_busy", {31'd0, busy}, 0);
    chk("rst_wd_tx_data", {24'd0, tx_data}, 0);
    chk("rst_wd_owner", {31'd0, owner}, 1);
    chk("rst_wd_start", {31'd0, tx_start}, 0);
    #1 rst = 0;
    tb_ready = 1;
    @(posedge clk); #1;
    chk("no_resend_after_rst", {31'd0, tx_start}, 0);
    req0 = 1; data0 = 8'h99;
    @(posedge clk); #1;
    chk("post_rst_start", {31'd0, tx_start}, 1);
    chk("post_rst_ack0", {31'd0, ack0}, 1);
    chk("post_rst_data", {24'd0, tx_data}, 8'h99);
    chk("post_rst_owner", {31'd0, owner}, 0);
    req0 = 0;

    for (int t = 0; t < 8; t++) run_random();

    // GAP instance: single requester held high.
    apply_reset();
    gap_req = 1;
    starts = 0; last = 0; bcnt = 0; cyc = 0;
    while (starts < 4 && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
      if (starts > 0) bcnt += g_busy ? 1 : 0;
      if (g_start) begin
        chk("gap_data", {24'd0, g_data}, 8'h5A);
        if (starts > 0) begin
          chk("gap_spacing", cyc - last, G_FRAME + 2 + GAP_N);
          chk("gap_busy_cycles", bcnt, G_FRAME + 1 + GAP_N);
        end
        last = cyc; bcnt = 0; starts++;
      end
    end
    chk("gap_start_count", starts, 4);
    gap_req = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
